piso_tx: RTL and testbench
==========================

PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 8, the data word width in bits; legal range 2..64.
REQ-002 SHALL have parameter MSB_FIRST, default 1; 1 transmits bit WIDTH-1 first, 0 transmits bit 0 first.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port din  input  WIDTH  the parallel word to transmit.
REQ-006 SHALL have port din_valid  input  1  din is valid this cycle.
REQ-007 SHALL have port din_ready  output  1  the block accepts din this cycle.
REQ-008 SHALL have port sout  output  1  the serial data bit, registered.
REQ-009 SHALL have port sframe  output  1  high in every cycle in which sout carries a frame bit, registered.
REQ-010 SHALL have port done  output  1  single-cycle pulse coincident with the last bit of a frame, registered.

Function
REQ-011 SHALL implement states IDLE and SHIFT; PARITY is added only under REQ-024.
REQ-012 SHALL accept a word on a posedge where din_valid=1 and din_ready=1, loading din into the shift register and the bit counter into WIDTH-1.
REQ-013 SHALL drive din_ready=1 in IDLE and in the final bit cycle of a frame, and 0 in all other cycles.
REQ-014 SHALL present the first bit on sout, with sframe=1, in the cycle after acceptance; latency from acceptance to the first bit is 1 cycle.
REQ-015 SHALL shift one bit per cycle, so each frame occupies exactly WIDTH consecutive cycles with sframe=1.
REQ-016 SHALL pulse done=1 for exactly the final bit cycle of each frame.
REQ-017 SHALL, on acceptance during the final bit cycle, start the next frame in the immediately following cycle: no gap, sframe stays 1, and done pulses once per frame.
REQ-018 SHALL, when no new word is accepted in the final bit cycle, return to IDLE with sframe=0, sout=0 and done=0.
REQ-019 SHALL ignore din_valid while din_ready=0; din is sampled only on acceptance, and later changes to din do not affect the frame in flight.
REQ-020 SHALL keep sout=0 whenever sframe=0.

Reset
REQ-021 SHALL, on rst=0, immediately and asynchronously force state to IDLE, the shift register and counter to 0, sout=0, sframe=0 and done=0.
REQ-022 SHALL drive din_ready=1 while in reset and in the first cycle after reset release.
REQ-023 SHALL discard a frame in progress when reset is asserted mid-frame, with no partial resumption after release.

Configuration
REQ-024 SHALL, when macro PISO_TX_PARITY_EN is defined, append one even-parity bit (XOR of all WIDTH data bits) after the data bits, carried in state PARITY.
REQ-025 SHALL, with parity enabled, make each frame WIDTH+1 cycles long and treat the parity cycle as the final bit cycle for din_ready and done.
REQ-026 SHALL, without PISO_TX_PARITY_EN, contain no parity logic or state, and frames are WIDTH cycles long.

Structure
REQ-027 SHALL place the state enum (IDLE, SHIFT, PARITY) and the constant PISO_TX_DEFAULT_WIDTH=8 in a shared package piso_tx_pkg.
REQ-028 SHALL implement the down-counter and its last-bit flag as sub-module piso_tx_bitcnt, with a width of $clog2(WIDTH+1).

Verification
REQ-029 SHALL cover MSB_FIRST=1, WIDTH=8, din=8'h1E accepted at cycle 0 -> sout=0,0,0,1,1,1,1,0 in cycles 1..8, sframe=1 in cycles 1..8, done=1 in cycle 8 only.
REQ-030 SHALL cover MSB_FIRST=0, din=8'h1E -> sout=0,1,1,1,1,0,0,0, and sframe=0 in cycle 9.
REQ-031 SHALL cover back-to-back 8'hFF then 8'h00, with the second accepted in cycle 8 -> sout=1 in cycles 1..8, sout=0 in cycles 9..16, sframe continuous, done in cycles 8 and 16.
REQ-032 SHALL cover rst=0 asserted mid-cycle in cycle 4 of a frame -> sout, sframe and done go to 0 without waiting for a clock edge; din_ready=1; after release a new word 8'h81 transmits cleanly.
REQ-033 SHALL cover din changed and din_valid held 1 during cycles 2..7 of a frame -> transmitted bits are unchanged and there is no extra acceptance.
REQ-034 SHALL cover PISO_TX_PARITY_EN defined, din=8'h07, MSB_FIRST=1 -> sout=0,0,0,0,0,1,1,1 then parity 1 in cycle 9, done in cycle 9, frame length 9.

Source files
------------

// File: rtl/piso_tx_pkg.sv
// Shared FSM encoding and default word width for the piso_tx serializer.
package piso_tx_pkg;

  localparam int PISO_TX_DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

endpackage

// File: rtl/piso_tx_bitcnt.sv
// Bit down-counter for a piso_tx frame: loads WIDTH-1 on acceptance, counts to 0.
// Output last is high while the final data bit is on the line.
module piso_tx_bitcnt
  import piso_tx_pkg::*;
#(
  parameter int WIDTH = PISO_TX_DEFAULT_WIDTH,
  localparam int CW   = $clog2(WIDTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          dec,
  output logic [CW-1:0] cnt,
  output logic          last
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(WIDTH - 1);
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign last = (cnt == '0);

endmodule

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: first bit 1 cycle after acceptance, frames may run back to back.
// din_ready is high only in IDLE and the final bit cycle; PISO_TX_PARITY_EN appends an even-parity bit.
module piso_tx
  import piso_tx_pkg::*;
#(
  parameter int WIDTH     = PISO_TX_DEFAULT_WIDTH,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sframe,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state, state_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic [CW-1:0]    cnt;
  logic             last, load, dec, final_bit, accept;
  logic             sout_n, sframe_n, done_n, first_bit;

  piso_tx_bitcnt #(.WIDTH(WIDTH)) u_bitcnt (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .dec  (dec),
    .cnt  (cnt),
    .last (last)
  );

`ifdef PISO_TX_PARITY_EN
  logic par_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      par_q <= 1'b0;
    else if (load) par_q <= ^din;
  end

  assign final_bit = (state == PARITY);
`else
  assign final_bit = (state == SHIFT) && last;
`endif

  assign din_ready = (state == IDLE) || final_bit;
  assign accept    = din_valid && din_ready;
  assign first_bit = (MSB_FIRST != 0) ? din[WIDTH-1] : din[0];

  always_comb begin
    state_n  = state;
    shreg_n  = shreg;
    sout_n   = 1'b0;
    sframe_n = 1'b0;
    done_n   = 1'b0;
    load     = 1'b0;
    dec      = 1'b0;
    case (state)
      IDLE: ;
      SHIFT: begin
        if (!last) begin
          // shreg keeps the on-line bit at its edge, so the next bit sits one place inward
          dec      = 1'b1;
          shreg_n  = (MSB_FIRST != 0) ? (shreg << 1) : (shreg >> 1);
          sout_n   = (MSB_FIRST != 0) ? shreg[WIDTH-2] : shreg[1];
          sframe_n = 1'b1;
`ifndef PISO_TX_PARITY_EN
          done_n   = (cnt == CW'(1));
`endif
        end
`ifdef PISO_TX_PARITY_EN
        else begin
          state_n  = PARITY;
          sout_n   = par_q;
          sframe_n = 1'b1;
          done_n   = 1'b1;
        end
`endif
      end
`ifdef PISO_TX_PARITY_EN
      PARITY: ;
`endif
      default: state_n = IDLE;
    endcase
    if (accept) begin
      load     = 1'b1;
      state_n  = SHIFT;
      shreg_n  = din;
      sout_n   = first_bit;
      sframe_n = 1'b1;
      done_n   = 1'b0;
    end else if (final_bit) begin
      state_n  = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      shreg  <= '0;
      sout   <= 1'b0;
      sframe <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      shreg  <= shreg_n;
      sout   <= sout_n;
      sframe <= sframe_n;
      done   <= done_n;
    end
  end

endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx: MSB-first and LSB-first instances share stimulus and a queue-based frame model.
module tb_piso_tx;

  localparam int W = 8;
`ifdef PISO_TX_PARITY_EN
  localparam int FLEN = W + 1;
`else
  localparam int FLEN = W;
`endif
  localparam int PAR = FLEN - W;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         din_valid = 1'b0;
  logic [W-1:0] din = '0;
  logic         ready_m, sout_m, sframe_m, done_m;
  logic         ready_l, sout_l, sframe_l, done_l;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  piso_tx #(.WIDTH(W), .MSB_FIRST(1)) dut_m (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .din_ready(ready_m), .sout(sout_m), .sframe(sframe_m), .done(done_m)
  );

  piso_tx #(.WIDTH(W), .MSB_FIRST(0)) dut_l (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .din_ready(ready_l), .sout(sout_l), .sframe(sframe_l), .done(done_l)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: queue of line cycles still to show; the head is what is on the line now.
  typedef struct packed {
    logic bm;
    logic bl;
    logic dn;
  } ent_t;

  ent_t q[$];

  always @(posedge clk or negedge rst) begin
    logic rdy;
    ent_t e;
    if (!rst) begin
      q.delete();
    end else begin
      rdy = (q.size() <= 1);
      if (q.size() > 0) void'(q.pop_front());
      if (din_valid && rdy) begin
        for (int i = 0; i < W; i++) begin
          e.bm = din[W-1-i];
          e.bl = din[i];
          e.dn = (i == FLEN - 1);
          q.push_back(e);
        end
        if (PAR != 0) begin
          e.bm = ^din;
          e.bl = ^din;
          e.dn = 1'b1;
          q.push_back(e);
        end
      end
    end
  end

  always @(negedge clk) begin
    ent_t e;
    logic er, ef;
    e  = (q.size() > 0) ? q[0] : '0;
    ef = (q.size() > 0);
    er = (q.size() <= 1);
    check("ready_msb",  ready_m,  er);
    check("sout_msb",   sout_m,   e.bm);
    check("sframe_msb", sframe_m, ef);
    check("done_msb",   done_m,   e.dn);
    check("ready_lsb",  ready_l,  er);
    check("sout_lsb",   sout_l,   e.bl);
    check("sframe_lsb", sframe_l, ef);
    check("done_lsb",   done_l,   e.dn);
  end

  // Sends d from IDLE and records n line cycles after acceptance; cycle c lands at bit n-c.
  // mode 0: single word; 1: hold valid with din=0 for a back-to-back second word;
  // 2: keep valid high and scramble din while the frame is busy.
  task automatic frame(input logic [W-1:0] d, input int mode, input int n,
                       output logic [31:0] so_m, output logic [31:0] so_l,
                       output logic [31:0] sf, output logic [31:0] dn);
    so_m = '0; so_l = '0; sf = '0; dn = '0;
    @(negedge clk);
    din = d;
    din_valid = 1'b1;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      so_m = {so_m[30:0], sout_m};
      so_l = {so_l[30:0], sout_l};
      sf   = {sf[30:0], sframe_m};
      dn   = {dn[30:0], done_m};
      case (mode)
        0: if (c == 1) din_valid = 1'b0;
        1: begin
          if (c == 1) din = '0;
          if (c == FLEN + 1) din_valid = 1'b0;
        end
        default: begin
          if (c < FLEN) din = W'($urandom);
          else          din_valid = 1'b0;
        end
      endcase
    end
  endtask

  initial begin
    logic [31:0] so_m, so_l, sf, dn;
    logic [31:0] sf_one;

    sf_one = ((32'd1 << FLEN) - 1) << 1;

    #1 rst = 1'b0;
    #2;
    check("rst_sout",   sout_m,   1'b0);
    check("rst_sframe", sframe_m, 1'b0);
    check("rst_done",   done_m,   1'b0);
    check("rst_ready",  ready_m,  1'b1);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);

    // 8'h1E single frame, both bit orders
    frame(8'h1E, 0, FLEN + 1, so_m, so_l, sf, dn);
    check("h1e_sout_msb", so_m, 32'h1E << (PAR + 1));
    check("h1e_sout_lsb", so_l, 32'h78 << (PAR + 1));
    check("h1e_sframe",   sf,   sf_one);
    check("h1e_done",     dn,   32'h2);
    repeat (2) @(negedge clk);

    // FF then 00 back to back
    frame(8'hFF, 1, 2 * FLEN + 1, so_m, so_l, sf, dn);
    check("b2b_sout_msb", so_m, 32'hFF << (FLEN + PAR + 1));
    check("b2b_sout_lsb", so_l, 32'hFF << (FLEN + PAR + 1));
    check("b2b_sframe",   sf,   ((32'd1 << (2 * FLEN)) - 1) << 1);
    check("b2b_done",     dn,   (32'd1 << (FLEN + 1)) | 32'h2);
    repeat (2) @(negedge clk);

    // din scrambled with valid held while busy
    frame(8'hC9, 2, FLEN + 1, so_m, so_l, sf, dn);
    check("hold_sout_msb", so_m, 32'hC9 << (PAR + 1));
    check("hold_sout_lsb", so_l, 32'h93 << (PAR + 1));
    check("hold_done",     dn,   32'h2);
    repeat (2) @(negedge clk);

    // asynchronous reset in cycle 4 of a frame
    @(negedge clk);
    din = 8'h5A;
    din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 check("mid_sframe_pre", sframe_m, 1'b1);
    #1 rst = 1'b0;
    #1;
    check("mid_sout_msb",   sout_m,   1'b0);
    check("mid_sframe_msb", sframe_m, 1'b0);
    check("mid_done_msb",   done_m,   1'b0);
    check("mid_sframe_lsb", sframe_l, 1'b0);
    check("mid_ready",      ready_m,  1'b1);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    frame(8'h81, 0, FLEN + 1, so_m, so_l, sf, dn);
    check("post_rst_sout_msb", so_m, 32'h81 << (PAR + 1));
    check("post_rst_sout_lsb", so_l, 32'h81 << (PAR + 1));
    check("post_rst_sframe",   sf,   sf_one);
    repeat (2) @(negedge clk);

`ifdef PISO_TX_PARITY_EN
    frame(8'h07, 0, FLEN + 1, so_m, so_l, sf, dn);
    check("par_sout_msb", so_m, 32'h1E);
    check("par_sout_lsb", so_l, 32'h382);
    check("par_sframe",   sf,   32'h3FE);
    check("par_done",     dn,   32'h2);
    repeat (2) @(negedge clk);
`endif

    // random traffic with occasional short resets
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      din_valid = ($urandom_range(0, 3) != 0);
      din = W'($urandom);
      if ($urandom_range(0, 499) == 0) begin
        #2 rst = 1'b0;
        #1 rst = 1'b1;
      end
    end
    @(negedge clk);
    din_valid = 1'b0;
    repeat (FLEN + 3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
